// File: rtl/rename_free_list_ctrl.sv
// Physical-register free list for the rename stage: one grant and one release per
// cycle, branch checkpoints of the list head, and post-reset list initialisation.
module rename_free_list_ctrl #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_CKPT      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alloc_req_i,
  output logic                             alloc_grant_o,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] alloc_tag_o,
  input  logic                             rel_valid_i,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] rel_tag_i,
  input  logic                             ckpt_take_i,
  output logic                             ckpt_ok_o,
  output logic [$clog2(NUM_CKPT)-1:0]      ckpt_id_o,
  input  logic                             ckpt_resolve_i,
  input  logic                             recover_i,
  input  logic [$clog2(NUM_CKPT)-1:0]      recover_id_i,
  output logic                             ready_o,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] free_count_o,
  output logic                             ckpt_full_o,
  output logic                             err_o
);
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int TW    = $clog2(NUM_PHYS_REGS);
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;
  localparam int CW    = $clog2(NUM_CKPT);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_RECOVER = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, free_q, free_d;
  logic [CW:0]     ck_rd_q, ck_rd_d, ck_wr_q, ck_wr_d, ck_cnt_q, ck_cnt_d;
  logic            err_q, err_d;
  logic [IW-1:0]   init_idx_q, init_idx_d;
  logic [TW-1:0]   list_q [DEPTH];
  logic [PW-1:0]   ckpt_head_q [NUM_CKPT];

  logic            run_s, grant_s, ckok_s, ckfull_s, rel_acc_s, res_ok_s, live_s;
  logic            list_we_s, ck_we_s;
  logic [IW-1:0]   list_wa_s;
  logic [TW-1:0]   list_wd_s;
  logic [PW-1:0]   head_next_s, free_after_g_s;
  logic [CW:0]     rd_res_s, cnt_res_s;
  logic [CW-1:0]   dist_s;

  assign run_s       = (state_q == S_RUN);
  assign ckfull_s    = (ck_cnt_q == (CW+1)'(NUM_CKPT));
  assign grant_s     = run_s & alloc_req_i & (free_q != {PW{1'b0}}) & ~recover_i;
  assign ckok_s      = run_s & ckpt_take_i & ~ckfull_s & ~recover_i;
  assign head_next_s = head_q + PW'(grant_s);

  assign alloc_grant_o = grant_s;
  assign alloc_tag_o   = list_q[head_q[IW-1:0]];
  assign ckpt_ok_o     = ckok_s;
  assign ckpt_id_o     = ck_wr_q[CW-1:0];
  assign ready_o       = run_s;
  assign free_count_o  = free_q;
  assign ckpt_full_o   = ckfull_s;
  assign err_o         = err_q;

  // Next-state for pointers, counters, checkpoint FIFO and the phase FSM.
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    free_d         = free_q;
    ck_rd_d        = ck_rd_q;
    ck_wr_d        = ck_wr_q;
    ck_cnt_d       = ck_cnt_q;
    err_d          = err_q;
    init_idx_d     = init_idx_q;
    list_we_s      = 1'b0;
    list_wa_s      = tail_q[IW-1:0];
    list_wd_s      = rel_tag_i;
    ck_we_s        = 1'b0;
    rel_acc_s      = 1'b0;
    res_ok_s       = 1'b0;
    live_s         = 1'b0;
    free_after_g_s = free_q - PW'(grant_s);
    rd_res_s       = ck_rd_q;
    cnt_res_s      = ck_cnt_q;
    dist_s         = {CW{1'b0}};
    case (state_q)
      S_INIT: begin
        list_we_s  = 1'b1;
        list_wa_s  = init_idx_q;
        list_wd_s  = TW'(init_idx_q) + TW'(DEPTH);
        tail_d     = tail_q + PW'(1);
        free_d     = free_q + PW'(1);
        init_idx_d = init_idx_q + IW'(1);
        if (init_idx_q == {IW{1'b1}}) begin
          state_d = S_RUN;
        end else begin
          state_d = S_INIT;
        end
      end
      S_RUN, S_RECOVER: begin
        state_d = S_RUN;
        if (rel_valid_i) begin
          if (free_after_g_s == PW'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            rel_acc_s = 1'b1;
            list_we_s = 1'b1;
            tail_d    = tail_q + PW'(1);
          end
        end else begin
          rel_acc_s = 1'b0;
        end
        res_ok_s = ckpt_resolve_i & (ck_cnt_q != {(CW+1){1'b0}});
        if (ckpt_resolve_i && !res_ok_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        rd_res_s  = ck_rd_q + (CW+1)'(res_ok_s);
        cnt_res_s = ck_cnt_q - (CW+1)'(res_ok_s);
        head_d    = head_next_s;
        free_d    = free_q + PW'(rel_acc_s) - PW'(grant_s);
        ck_rd_d   = rd_res_s;
        ck_wr_d   = ck_wr_q + (CW+1)'(ckok_s);
        ck_cnt_d  = cnt_res_s + (CW+1)'(ckok_s);
        ck_we_s   = ckok_s;
        // Liveness is judged after this cycle's resolve has retired the oldest slot.
        if (run_s && recover_i) begin
          dist_s = recover_id_i - rd_res_s[CW-1:0];
          live_s = ({1'b0, dist_s} < cnt_res_s);
          if (live_s) begin
            head_d   = ckpt_head_q[recover_id_i];
            free_d   = free_q + PW'(rel_acc_s) + (head_q - ckpt_head_q[recover_id_i]);
            ck_wr_d  = rd_res_s + {1'b0, dist_s} + (CW+1)'(1);
            ck_cnt_d = {1'b0, dist_s} + (CW+1)'(1);
            state_d  = S_RECOVER;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          live_s = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      free_q     <= {PW{1'b0}};
      ck_rd_q    <= {(CW+1){1'b0}};
      ck_wr_q    <= {(CW+1){1'b0}};
      ck_cnt_q   <= {(CW+1){1'b0}};
      err_q      <= 1'b0;
      init_idx_q <= {IW{1'b0}};
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      free_q     <= free_d;
      ck_rd_q    <= ck_rd_d;
      ck_wr_q    <= ck_wr_d;
      ck_cnt_q   <= ck_cnt_d;
      err_q      <= err_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Tag storage and checkpoint slots; contents are rebuilt by INIT, so no reset.
  always_ff @(posedge clk) begin
    if (list_we_s) begin
      list_q[list_wa_s] <= list_wd_s;
    end
    if (ck_we_s) begin
      ckpt_head_q[ck_wr_q[CW-1:0]] <= head_next_s;
    end
  end
endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Bench for rename_free_list_ctrl: directed scenarios plus random traffic, all
// checked against a queue/integer model of the free list and checkpoint FIFO.
module tb_rename_free_list_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0, rel_valid = 1'b0, ckpt_take = 1'b0;
  logic       ckpt_resolve = 1'b0, recover = 1'b0;
  logic [5:0] rel_tag = 6'd0;
  logic [1:0] recover_id = 2'd0;
  logic       alloc_grant, ckpt_ok, ready, ckpt_full, err;
  logic [5:0] alloc_tag, free_count;
  logic [1:0] ckpt_id;

  int n_chk = 0;
  int n_err = 0;

  rename_free_list_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req), .alloc_grant_o(alloc_grant), .alloc_tag_o(alloc_tag),
    .rel_valid_i(rel_valid), .rel_tag_i(rel_tag),
    .ckpt_take_i(ckpt_take), .ckpt_ok_o(ckpt_ok), .ckpt_id_o(ckpt_id),
    .ckpt_resolve_i(ckpt_resolve), .recover_i(recover), .recover_id_i(recover_id),
    .ready_o(ready), .free_count_o(free_count), .ckpt_full_o(ckpt_full), .err_o(err)
  );

  always #5 clk = ~clk;

  // Reference model: unbounded head/tail counters over a 32-entry ring, checkpoint FIFO as a queue.
  typedef struct {int id; int hd;} ck_t;
  int         m_state;  // 0 init, 1 run, 2 recover bubble
  int         m_init, m_head, m_tail, m_next_id;
  bit         m_err, e_grant, e_ckok;
  logic [5:0] m_mem [32];
  ck_t        m_ck [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_init = 0; m_head = 0; m_tail = 0; m_next_id = 0; m_err = 1'b0;
    m_ck.delete();
  endtask

  function automatic int m_free();
    return (m_state == 0) ? m_init : (m_tail - m_head);
  endfunction

  task automatic model_step();
    int nh;
    int idx;
    if (m_state == 0) begin
      m_mem[m_init] = 6'(m_init + 32);
      m_init++;
      if (m_init == 32) begin
        m_state = 1; m_head = 0; m_tail = 32;
      end
      return;
    end
    nh = m_head + int'(e_grant);
    if (rel_valid) begin
      if (m_tail - m_head - int'(e_grant) == 32) m_err = 1'b1;
      else begin
        m_mem[m_tail % 32] = rel_tag;
        m_tail++;
      end
    end
    if (ckpt_resolve) begin
      if (m_ck.size() > 0) void'(m_ck.pop_front());
      else m_err = 1'b1;
    end
    if (e_ckok) begin
      m_ck.push_back('{m_next_id, nh});
      m_next_id = (m_next_id + 1) % 4;
    end
    m_head = nh;
    if (m_state == 2) m_state = 1;
    else if (recover) begin
      idx = -1;
      foreach (m_ck[i]) if (m_ck[i].id == int'(recover_id)) idx = i;
      if (idx < 0) m_err = 1'b1;
      else begin
        m_head = m_ck[idx].hd;
        while (m_ck.size() > idx + 1) void'(m_ck.pop_back());
        m_next_id = (int'(recover_id) + 1) % 4;
        m_state = 2;
      end
    end
  endtask

  // One clock: compare outputs for the inputs already applied, then advance the model.
  task automatic cycle();
    #1;
    e_grant = (m_state == 1) && alloc_req && (m_free() != 0) && !recover;
    e_ckok  = (m_state == 1) && ckpt_take && (m_ck.size() != 4) && !recover;
    check("ready", ready, (m_state == 1));
    check("free_count", free_count, m_free());
    check("ckpt_full", ckpt_full, (m_ck.size() == 4));
    check("err", err, m_err);
    check("alloc_grant", alloc_grant, e_grant);
    if (e_grant) check("alloc_tag", alloc_tag, m_mem[m_head % 32]);
    check("ckpt_ok", ckpt_ok, e_ckok);
    if (e_ckok) check("ckpt_id", ckpt_id, m_next_id);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input bit a, input bit rv, input int rt, input bit ct,
                        input bit cr, input bit rc, input int rid);
    alloc_req = a; rel_valid = rv; rel_tag = 6'(rt); ckpt_take = ct;
    ckpt_resolve = cr; recover = rc; recover_id = 2'(rid);
  endtask

  // Pulse reset at a negedge, check the immediate reset outputs, release at the next negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_free"}, free_count, 6'd0);
    check({tag, "_grant"}, alloc_grant, 1'b0);
    check({tag, "_ckok"}, ckpt_ok, 1'b0);
    check({tag, "_ckfull"}, ckpt_full, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_reset("rst0");

    // Init then drain: 32 bubble cycles, tags 32..63, then one empty cycle.
    repeat (65) cycle();
    check("drain_free", free_count, 6'd0);

    set_in(1'b0, 1'b1, 40, 1'b0, 1'b0, 1'b0, 0);
    cycle();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    #1 check("refill_tag", alloc_tag, 6'd40);
    cycle();

    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 41 + i, 1'b0, 1'b0, 1'b0, 0);
      cycle();
    end
    set_in(1'b1, 1'b1, 46, 1'b0, 1'b0, 1'b0, 0);
    cycle();
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    cycle();
    check("simul_free", free_count, 6'd5);

    // Checkpoint at head 3, four grants, recover to slot 0.
    do_reset("rst1");
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (32) cycle();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) cycle();
    set_in(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    #1 check("ck_take_id", ckpt_id, 2'd0);
    cycle();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (4) cycle();
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    cycle();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    #1 check("bubble_ready", ready, 1'b0);
    cycle();
    #1 check("recov_tag", alloc_tag, 6'd35);
    check("recov_free", free_count, 6'd29);
    cycle();

    // Fill the checkpoint FIFO, resolve one, then recover with a resolved id.
    set_in(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) cycle();
    check("ck_full", ckpt_full, 1'b1);
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    cycle();
    check("ck_not_full", ckpt_full, 1'b0);
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    cycle();
    check("stale_err", err, 1'b1);

    // Reset while in the recover bubble.
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1);
    cycle();
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    do_reset("rst_rec");
    repeat (40) cycle();

    // Random traffic, mostly legal, with occasional protocol errors and resets.
    for (int n = 0; n < 4000; n++) begin
      int rid;
      bit rv, cr, rc;
      rv  = ($urandom_range(0, 2) == 0) && (m_free() < 32 || $urandom_range(0, 30) == 0);
      cr  = ($urandom_range(0, 6) == 0) && (m_ck.size() > 0 || $urandom_range(0, 20) == 0);
      rc  = ($urandom_range(0, 12) == 0);
      rid = (m_ck.size() > 0 && $urandom_range(0, 3) != 0)
            ? m_ck[$urandom_range(0, m_ck.size() - 1)].id : int'($urandom_range(0, 3));
      set_in($urandom_range(0, 3) != 0, rv, int'($urandom_range(0, 63)),
             $urandom_range(0, 4) == 0, cr, rc, rid);
      if ($urandom_range(0, 900) == 0) do_reset("rst_rand");
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
